// File: rtl/uart_pkg.sv
// Encodings, FSM state type and baud divisor helper shared by the parametrised UART transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_hz(input logic [1:0] sel);
    case (sel)
      BAUD_2400: baud_hz = 2400;
      BAUD_4800: baud_hz = 4800;
      BAUD_9600: baud_hz = 9600;
      default:   baud_hz = 19200;
    endcase
  endfunction

  // Divisor rounded to the nearest whole clock count.
  function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
    int hz;
    hz = baud_hz(sel);
    baud_div = (clk_freq + hz / 2) / hz;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int DIV_W = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_restart,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_count;

  assign o_bit_end = i_en && (r_count == (i_div - ONE));

  always_ff @(posedge clock) begin
    if (reset || i_restart || o_bit_end || !i_en) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one-word holding buffer feeding a start/data/parity/stop serialiser
// whose frame configuration is frozen at every frame start.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = $clog2(CLK_FREQ / 2400 + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic [1:0]        baud_rate,
  input  logic              stop_bits,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag
);

  localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(baud_div(CLK_FREQ, BAUD_2400));
  localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(baud_div(CLK_FREQ, BAUD_4800));
  localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(baud_div(CLK_FREQ, BAUD_9600));
  localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(baud_div(CLK_FREQ, BAUD_19200));
  localparam logic [3:0]       LAST_DATA = 4'(DATA_W - 1);

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [1:0] sel);
    parity_bit = (sel == PAR_ODD) ? ~^d : ^d;
  endfunction

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_hold_data;
  logic [DATA_W-1:0] r_shift;
  logic              r_hold_full;
  logic              r_tx;
  logic              r_active;
  logic              r_done;
  logic              r_par_bit;
  logic              r_cfg_stop2;
  logic [1:0]        r_cfg_par;
  logic [1:0]        r_cfg_baud;
  logic [3:0]        r_bit_cnt;

  logic [DIV_W-1:0]  w_div;
  logic              w_bit_end;
  logic              w_accept;
  logic              w_busy;
  logic              w_last_stop;
  logic              w_start;
  logic              w_has_par;

  always_comb begin
    w_div = DIV_19200;
    case (r_cfg_baud)
      BAUD_2400: w_div = DIV_2400;
      BAUD_4800: w_div = DIV_4800;
      BAUD_9600: w_div = DIV_9600;
      default:   w_div = DIV_19200;
    endcase
  end

  assign in_ready    = !r_hold_full && !reset;
  assign w_accept    = in_valid && in_ready;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (!r_cfg_stop2 || (r_bit_cnt == 4'd1));
  // A waiting word starts either from idle or seamlessly on the last cycle of the previous frame.
  assign w_start     = r_hold_full && ((r_state == ST_IDLE) || w_last_stop);
  assign w_has_par   = (r_cfg_par == PAR_ODD) || (r_cfg_par == PAR_EVEN);

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud_gen (
    .clock    (clock),
    .reset    (reset),
    .i_restart(w_start),
    .i_en     (w_busy),
    .i_div    (w_div),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_hold_data <= data_in;
    end
    if (w_start) begin
      r_shift   <= r_hold_data;
      r_par_bit <= parity_bit(r_hold_data, parity_type);
    end else if (w_bit_end && (r_state == ST_DATA)) begin
      r_shift <= r_shift >> 1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tx        <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= 4'd0;
      r_cfg_par   <= PAR_NONE;
      r_cfg_baud  <= BAUD_2400;
      r_cfg_stop2 <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_hold_full <= 1'b1;
      end else if (w_start) begin
        r_hold_full <= 1'b0;
      end

      if (w_start) begin
        r_state     <= ST_START;
        r_tx        <= 1'b0;
        r_active    <= 1'b1;
        r_bit_cnt   <= 4'd0;
        r_cfg_par   <= parity_type;
        r_cfg_baud  <= baud_rate;
        r_cfg_stop2 <= stop_bits;
        r_done      <= (r_state == ST_STOP);
      end else if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_bit_cnt <= 4'd0;
          end
          ST_DATA: begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= 4'd0;
              if (w_has_par) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          ST_PARITY: begin
            r_state   <= ST_STOP;
            r_tx      <= 1'b1;
            r_bit_cnt <= 4'd0;
          end
          ST_STOP: begin
            if (r_cfg_stop2 && (r_bit_cnt == 4'd0)) begin
              r_bit_cnt <= 4'd1;
            end else begin
              r_state  <= ST_IDLE;
              r_tx     <= 1'b1;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: 8-bit and 7-bit instances at a reduced clock so frames stay short.
module tb_uart_tx_param;

  localparam int CLK = 100_000;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] par   = 2'b00;
  logic [1:0] baud  = 2'b00;
  logic       stop2 = 1'b0;

  logic       a_valid = 1'b0;
  logic [7:0] a_data  = 8'h00;
  logic       a_ready, a_tx, a_active, a_done;
  logic       b_valid = 1'b0;
  logic [6:0] b_data  = 7'h00;
  logic       b_ready, b_tx, b_active, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(CLK), .DATA_W(8)) dut_a (
    .clock(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_ready), .data_in(a_data),
    .parity_type(par), .baud_rate(baud), .stop_bits(stop2),
    .data_tx(a_tx), .active_flag(a_active), .done_flag(a_done)
  );

  uart_tx_param #(.CLK_FREQ(CLK), .DATA_W(7)) dut_b (
    .clock(clk), .reset(rst), .in_valid(b_valid), .in_ready(b_ready), .data_in(b_data),
    .parity_type(par), .baud_rate(baud), .stop_bits(stop2),
    .data_tx(b_tx), .active_flag(b_active), .done_flag(b_done)
  );

  // Reference model: bit period from the nominal baud rate, frame as a list of line levels.
  function automatic int model_div(input logic [1:0] sel);
    int hz;
    hz = 2400 << sel;
    return (CLK + hz / 2) / hz;
  endfunction

  function automatic void model_frame(input logic [8:0] w, input int dw, input logic [1:0] p,
                                      input logic s2, output logic [15:0] bits, output int n);
    int ones;
    bits = '1; n = 0; ones = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < dw; i++) begin
      bits[n] = w[i]; n++;
      if (w[i]) ones++;
    end
    if (p == 2'b01) begin bits[n] = ((ones % 2) == 0); n++; end
    if (p == 2'b10) begin bits[n] = ((ones % 2) == 1); n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
  endfunction

  task automatic send(input bit sel, input logic [8:0] w, input bit keep);
    int t = 0;
    if (sel) begin b_valid = 1'b1; b_data = w[6:0]; end
    else     begin a_valid = 1'b1; a_data = w[7:0]; end
    while ((sel ? b_ready : a_ready) !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if (t >= 5000) begin errors++; $display("FAIL send_ready in_ready stuck low after %0d cycles, required 1", t); end
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin
      if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    end
  endtask

  // Observes one frame from its falling start edge; records levels, not verdicts.
  task automatic capture(input bit sel, input int n, input int div, output int waited,
                         output logic [15:0] obs, output logic [15:0] unst, output int done_in,
                         output int idle_in, output logic rdy0, output logic done_after,
                         output logic act_after, output logic tx_after);
    logic first, cur;
    waited = 0; obs = '1; unst = '0; done_in = 0; idle_in = 0;
    while ((sel ? b_tx : a_tx) !== 1'b0 && waited < 3000) begin @(negedge clk); waited++; end
    rdy0 = sel ? b_ready : a_ready;
    for (int s = 0; s < n; s++) begin
      first = sel ? b_tx : a_tx;
      for (int c = 0; c < div; c++) begin
        cur = sel ? b_tx : a_tx;
        if (cur !== first) unst[s] = 1'b1;
        if (c == div / 2) obs[s] = cur;
        if ((sel ? b_done : a_done) !== 1'b0) done_in++;
        if ((sel ? b_active : a_active) !== 1'b1) idle_in++;
        @(negedge clk);
      end
    end
    done_after = sel ? b_done : a_done;
    act_after  = sel ? b_active : a_active;
    tx_after   = sel ? b_tx : a_tx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (a_tx !== 1'b1)     begin errors++; $display("FAIL rst_tx got %b required 1", a_tx); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b required 0", a_active); end
    checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b required 0", a_done); end
    checks++; if (a_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready got %b required 0", a_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_ready_a got %b required 1", a_ready); end
    checks++; if (b_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_ready_b got %b required 1", b_ready); end
  endtask

  task automatic test_single_frame(input string nm, input bit sel, input logic [8:0] w,
                                   input logic [1:0] p, input logic [1:0] bd, input logic s2);
    int n, div, waited, done_in, idle_in;
    logic [15:0] exp, obs, unst;
    logic rdy0, da, aa, ta;
    par = p; baud = bd; stop2 = s2;
    model_frame(w, sel ? 7 : 8, p, s2, exp, n);
    div = model_div(bd);
    send(sel, w, 1'b0);
    capture(sel, n, div, waited, obs, unst, done_in, idle_in, rdy0, da, aa, ta);
    checks++; if (waited != 1)    begin errors++; $display("FAIL %s_start_latency got %0d required 1", nm, waited); end
    checks++; if (obs !== exp)    begin errors++; $display("FAIL %s_bits got %b required %b", nm, obs, exp); end
    checks++; if (unst !== 16'h0) begin errors++; $display("FAIL %s_bit_period unstable slots %b required 0", nm, unst); end
    checks++; if (done_in != 0)   begin errors++; $display("FAIL %s_early_done got %0d pulses required 0", nm, done_in); end
    checks++; if (idle_in != 0)   begin errors++; $display("FAIL %s_active_gap got %0d idle cycles required 0", nm, idle_in); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL %s_ready_after_load got %b required 1", nm, rdy0); end
    checks++; if (da !== 1'b1)    begin errors++; $display("FAIL %s_done_pulse got %b required 1", nm, da); end
    checks++; if (aa !== 1'b0)    begin errors++; $display("FAIL %s_active_end got %b required 0", nm, aa); end
    checks++; if (ta !== 1'b1)    begin errors++; $display("FAIL %s_line_idle got %b required 1", nm, ta); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL %s_done_width got a=%b b=%b required 0", nm, a_done, b_done); end
  endtask

  task automatic test_back_to_back();
    int n1, n2, div, w1, w2, d1, d2, i1, i2;
    logic [15:0] e1, e2, o1, o2, u1, u2;
    logic r1, r2, da1, da2, aa1, aa2, ta1, ta2;
    logic [7:0] junk;
    par = 2'($urandom_range(0, 3)); baud = 2'($urandom_range(1, 3)); stop2 = 1'($urandom_range(0, 1));
    model_frame(9'h055, 8, par, stop2, e1, n1);
    model_frame(9'h00F, 8, par, stop2, e2, n2);
    div  = model_div(baud);
    junk = 8'($urandom_range(16, 255));
    fork
      begin
        capture(1'b0, n1, div, w1, o1, u1, d1, i1, r1, da1, aa1, ta1);
        capture(1'b0, n2, div, w2, o2, u2, d2, i2, r2, da2, aa2, ta2);
      end
      begin
        send(1'b0, 9'h055, 1'b1);
        send(1'b0, 9'h00F, 1'b1);
        a_data = junk;
        repeat (20) @(negedge clk);
        a_valid = 1'b0;
      end
    join
    checks++; if (w1 != 2)        begin errors++; $display("FAIL b2b_first_latency got %0d required 2", w1); end
    checks++; if (o1 !== e1)      begin errors++; $display("FAIL b2b_bits1 got %b required %b", o1, e1); end
    checks++; if (u1 !== 16'h0)   begin errors++; $display("FAIL b2b_period1 unstable %b required 0", u1); end
    checks++; if (da1 !== 1'b1)   begin errors++; $display("FAIL b2b_done1 got %b required 1", da1); end
    checks++; if (aa1 !== 1'b1)   begin errors++; $display("FAIL b2b_active_between got %b required 1", aa1); end
    checks++; if (w2 != 0)        begin errors++; $display("FAIL b2b_gap got %0d cycles required 0", w2); end
    checks++; if (o2 !== e2)      begin errors++; $display("FAIL b2b_bits2 got %b required %b", o2, e2); end
    checks++; if (u2 !== 16'h0)   begin errors++; $display("FAIL b2b_period2 unstable %b required 0", u2); end
    checks++; if (d2 != 1)        begin errors++; $display("FAIL b2b_done_in_frame2 got %0d required 1", d2); end
    checks++; if (i2 != 0)        begin errors++; $display("FAIL b2b_active_frame2 got %0d idle cycles required 0", i2); end
    checks++; if (r1 !== 1'b1 || r2 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load got %b%b required 11", r1, r2); end
    checks++; if (da2 !== 1'b1 || aa2 !== 1'b0 || ta2 !== 1'b1) begin errors++; $display("FAIL b2b_end got done=%b active=%b tx=%b required 1 0 1", da2, aa2, ta2); end
  endtask

  task automatic test_baud_change();
    int n, div, w, d, i;
    logic [15:0] e, o, u;
    logic r, da, aa, ta;
    logic [8:0] word;
    par = 2'($urandom_range(0, 2)); baud = 2'b10; stop2 = 1'b0;
    word = 9'($urandom_range(0, 255));
    model_frame(word, 8, par, 1'b0, e, n);
    div = model_div(2'b10);
    send(1'b0, word, 1'b0);
    fork
      capture(1'b0, n, div, w, o, u, d, i, r, da, aa, ta);
      begin repeat (1 + 4 * div) @(negedge clk); baud = 2'b00; end
    join
    checks++; if (o !== e || u !== 16'h0) begin errors++; $display("FAIL baudchg_current got %b unstable %b required %b", o, u, e); end
    checks++; if (da !== 1'b1)            begin errors++; $display("FAIL baudchg_done got %b required 1", da); end
    word = 9'($urandom_range(0, 255));
    model_frame(word, 8, par, 1'b0, e, n);
    div = model_div(2'b00);
    send(1'b0, word, 1'b0);
    capture(1'b0, n, div, w, o, u, d, i, r, da, aa, ta);
    checks++; if (o !== e || u !== 16'h0) begin errors++; $display("FAIL baudchg_next got %b unstable %b required %b", o, u, e); end
    checks++; if (da !== 1'b1)            begin errors++; $display("FAIL baudchg_next_done got %b required 1", da); end
  endtask

  task automatic test_reset_mid_frame();
    int dones = 0, lows = 0;
    par = 2'b01; baud = 2'b10; stop2 = 1'b0;
    send(1'b0, 9'($urandom_range(0, 255)), 1'b0);
    send(1'b0, 9'($urandom_range(0, 255)), 1'b0);
    repeat (5 * model_div(2'b10) + 2) @(negedge clk);
    checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL rstmid_precondition active got %b required 1", a_active); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_tx !== 1'b1)     begin errors++; $display("FAIL rstmid_tx got %b required 1", a_tx); end
    checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b required 0", a_active); end
    checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL rstmid_done got %b required 0", a_done); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_hold_empty ready got %b required 1", a_ready); end
    repeat (200) begin
      if (a_done !== 1'b0) dones++;
      if (a_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses required 0", dones); end
    checks++; if (lows != 0)  begin errors++; $display("FAIL rstmid_no_restart got %0d low cycles required 0", lows); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      test_single_frame("rnd", 1'b0, 9'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame("odd9600", 1'b0, 9'h0AA, 2'b01, 2'b10, 1'b0);
    test_single_frame("even19200", 1'b0, 9'h0AA, 2'b10, 2'b11, 1'b1);
    test_back_to_back();
    test_baud_change();
    test_reset_mid_frame();
    test_single_frame("w7_none", 1'b1, 9'h07F, 2'b11, 2'b11, 1'b0);
    test_single_frame("w7_par", 1'b1, 9'($urandom_range(0, 127)), 2'($urandom_range(1, 2)), 2'b10, 1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
